// File: rtl/psum_drain_pkg.sv
// psum_drain_pkg: widths and types shared by the systolic-array partial-sum drain path.
package psum_drain_pkg;
    localparam int ARRAY_N    = 8;
    localparam int PSUM_W     = 24;
    localparam int FIFO_DEPTH = 4;
    localparam int ROW_W      = ARRAY_N * PSUM_W;
    localparam int COL_W      = $clog2(ARRAY_N);

    typedef logic signed [PSUM_W-1:0] psum_t;
    typedef logic [ROW_W-1:0]         row_t;
    typedef logic [COL_W-1:0]         col_t;

    function automatic psum_t relu(input psum_t v);
        return v[PSUM_W-1] ? '0 : v;
    endfunction
endpackage

// File: rtl/psum_drain_if.sv
// psum_drain_if: column capture inputs and per-element output stream of psum_drain.
interface psum_drain_if;
    import psum_drain_pkg::*;
    logic [ARRAY_N-1:0] psum_valid_in;
    row_t               psum_in;
    logic               out_valid;
    logic               out_ready;
    psum_t              out_data;
    col_t               out_col;
    logic               out_last;

    modport slave (
        input  psum_valid_in, psum_in, out_ready,
        output out_valid, out_data, out_col, out_last
    );
    modport master (
        output psum_valid_in, psum_in, out_ready,
        input  out_valid, out_data, out_col, out_last
    );
endinterface

// File: rtl/psum_drain_row_fifo.sv
// psum_drain_row_fifo: synchronous row FIFO; a push while full is accepted only if a pop frees a slot that cycle.
module psum_drain_row_fifo
    import psum_drain_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear,
    input  logic                       push,
    input  logic                       pop,
    input  row_t                       wr_data,
    output row_t                       rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    row_t          mem_q [DEPTH];
    logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign full    = count_q == CW'(DEPTH);
    assign empty   = count_q == '0;
    assign count   = count_q;
    assign rd_data = mem_q[rd_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_d    = do_push ? ((wr_q == AW'(DEPTH-1)) ? '0 : wr_q + 1'b1) : wr_q;
        rd_d    = do_pop ? ((rd_q == AW'(DEPTH-1)) ? '0 : rd_q + 1'b1) : rd_q;
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear)
            mem_q[wr_q] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else if (clear) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/psum_drain.sv
// psum_drain: deskews bottom-row partial sums into rows, queues them and streams one element per beat.
// Define PSUM_DRAIN_RELU_EN to clamp negative partial sums to zero at capture.
module psum_drain
    import psum_drain_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    psum_drain_if.slave       bus,
    output logic              almost_full,
    output logic              overflow
);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] STREAM = 1'b1;

    row_t               row_q, row_d, out_row_q, out_row_d, fifo_head;
    logic [ARRAY_N-1:0] mask_q, mask_d, mask_all;
    logic               ovf_q, ovf_d;
    logic [0:0]         state_q, state_d;
    col_t               col_q, col_d;
    logic               commit, drop, pop, last_beat, fifo_full, fifo_empty;
    logic [CW-1:0]      fifo_count;

    function automatic psum_t shape(input psum_t v);
`ifdef PSUM_DRAIN_RELU_EN
        return relu(v);
`else
        return v;
`endif
    endfunction

    always_comb begin
        row_d = row_q;
        for (int j = 0; j < ARRAY_N; j++)
            if (bus.psum_valid_in[j])
                row_d[j*PSUM_W +: PSUM_W] = shape(bus.psum_in[j*PSUM_W +: PSUM_W]);
    end

    // The push carries row_d so columns captured on the commit edge are included.
    always_comb begin
        mask_all  = mask_q | bus.psum_valid_in;
        commit    = &mask_all;
        mask_d    = commit ? '0 : mask_all;
        last_beat = (state_q == STREAM) && bus.out_ready && (col_q == COL_W'(ARRAY_N-1));
        pop       = !fifo_empty && ((state_q == IDLE) || last_beat);
        drop      = commit && fifo_full && !pop;
        ovf_d     = ovf_q || (|(bus.psum_valid_in & mask_q)) || drop;
        state_d   = pop ? STREAM : (last_beat ? IDLE : state_q);
        col_d     = pop ? '0 : (((state_q == STREAM) && bus.out_ready && !last_beat) ? col_q + 1'b1 : col_q);
        out_row_d = pop ? fifo_head : out_row_q;
    end

    psum_drain_row_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .push    (commit),
        .pop     (pop),
        .wr_data (row_d),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q     <= '0;
            mask_q    <= '0;
            ovf_q     <= 1'b0;
            state_q   <= IDLE;
            col_q     <= '0;
            out_row_q <= '0;
        end else if (clear) begin
            row_q     <= '0;
            mask_q    <= '0;
            ovf_q     <= 1'b0;
            state_q   <= IDLE;
            col_q     <= '0;
            out_row_q <= '0;
        end else begin
            row_q     <= row_d;
            mask_q    <= mask_d;
            ovf_q     <= ovf_d;
            state_q   <= state_d;
            col_q     <= col_d;
            out_row_q <= out_row_d;
        end
    end

    assign almost_full   = fifo_count >= CW'(DEPTH-1);
    assign overflow      = ovf_q;
    assign bus.out_valid = state_q == STREAM;
    assign bus.out_data  = out_row_q[col_q*PSUM_W +: PSUM_W];
    assign bus.out_col   = col_q;
    assign bus.out_last  = (state_q == STREAM) && (col_q == COL_W'(ARRAY_N-1));
endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: directed scenarios for psum_drain; inputs driven and outputs sampled on the falling edge.
module tb_psum_drain;
    import psum_drain_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear = 1'b0;
    logic almost_full, overflow;
    int   passed = 0;
    int   total = 0;

    psum_drain_if bus ();

    psum_drain dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .bus         (bus),
        .almost_full (almost_full),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic idle_in();
        bus.psum_valid_in = '0;
        bus.psum_in = '0;
    endtask

    task automatic set_col(input int j, input int v);
        bus.psum_valid_in[j] = 1'b1;
        bus.psum_in[j*PSUM_W +: PSUM_W] = PSUM_W'(v);
    endtask

    // Drives a whole row in one cycle; returns at the falling edge after the commit edge.
    task automatic push_row(input int base);
        idle_in();
        for (int j = 0; j < ARRAY_N; j++) set_col(j, base + j);
        @(negedge clk);
        idle_in();
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.out_valid); else passed++;
        total++; if (bus.out_data !== '0) $display("FAIL reset_data got %0d want 0", bus.out_data); else passed++;
        total++; if (bus.out_last !== 1'b0) $display("FAIL reset_last got %b want 0", bus.out_last); else passed++;
        total++; if (almost_full !== 1'b0) $display("FAIL reset_afull got %b want 0", almost_full); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow); else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_idle got %b want 0", bus.out_valid); else passed++;
    endtask

    task automatic test_skewed();
        bus.out_ready = 1'b0;
        for (int j = 0; j < ARRAY_N; j++) begin
            idle_in();
            set_col(j, j*100 - 300);
            @(negedge clk);
        end
        idle_in();
        total++; if (bus.out_valid !== 1'b0) $display("FAIL skew_lat_e got %b want 0", bus.out_valid); else passed++;
        @(negedge clk);
        total++; if (bus.out_valid !== 1'b1) $display("FAIL skew_lat_e1 got %b want 1", bus.out_valid); else passed++;
        bus.out_ready = 1'b1;
        for (int b = 0; b < ARRAY_N; b++) begin
            total++;
            if ({bus.out_valid, bus.out_data, bus.out_col, bus.out_last} !== {1'b1, psum_t'(b*100 - 300), col_t'(b), b == 7})
                $display("FAIL skew_beat%0d got v=%b d=%0d c=%0d l=%b want d=%0d c=%0d", b, bus.out_valid, bus.out_data, bus.out_col, bus.out_last, b*100 - 300, b);
            else passed++;
            @(negedge clk);
        end
        total++; if (bus.out_valid !== 1'b0) $display("FAIL skew_end got %b want 0", bus.out_valid); else passed++;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        push_row(1000);
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            total++;
            if ({bus.out_valid, bus.out_data, bus.out_col} !== {1'b1, psum_t'(1000 + b), col_t'(b)})
                $display("FAIL bp_pre%0d got d=%0d c=%0d want d=%0d c=%0d", b, bus.out_data, bus.out_col, 1000 + b, b);
            else passed++;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        repeat (5) begin
            total++;
            if ({bus.out_valid, bus.out_data, bus.out_col} !== {1'b1, psum_t'(1003), col_t'(3)})
                $display("FAIL bp_hold got v=%b d=%0d c=%0d want d=1003 c=3", bus.out_valid, bus.out_data, bus.out_col);
            else passed++;
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        for (int b = 3; b < ARRAY_N; b++) begin
            total++;
            if ({bus.out_valid, bus.out_data, bus.out_col, bus.out_last} !== {1'b1, psum_t'(1000 + b), col_t'(b), b == 7})
                $display("FAIL bp_post%0d got d=%0d c=%0d l=%b want d=%0d c=%0d", b, bus.out_data, bus.out_col, bus.out_last, 1000 + b, b);
            else passed++;
            @(negedge clk);
        end
        total++; if (bus.out_valid !== 1'b0) $display("FAIL bp_end got %b want 0", bus.out_valid); else passed++;
        bus.out_ready = 1'b0;
    endtask

    // Row 0 moves into the output register, so rows 1-4 fill the FIFO and row 5 is dropped.
    task automatic test_fill();
        bus.out_ready = 1'b0;
        for (int r = 0; r < 6; r++) begin
            push_row((r + 1) * 1000);
            if (r == 2) begin
                total++; if (almost_full !== 1'b0) $display("FAIL fill_af_r2 got %b want 0", almost_full); else passed++;
            end
            if (r == 3) begin
                total++; if (almost_full !== 1'b1) $display("FAIL fill_af_r3 got %b want 1", almost_full); else passed++;
            end
            if (r == 4) begin
                total++; if (overflow !== 1'b0) $display("FAIL fill_ovf_r4 got %b want 0", overflow); else passed++;
            end
            if (r == 5) begin
                total++; if (overflow !== 1'b1) $display("FAIL fill_ovf_r5 got %b want 1", overflow); else passed++;
            end
        end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5 * ARRAY_N; k++) begin
            total++;
            if ({bus.out_valid, bus.out_data, bus.out_col} !== {1'b1, psum_t'((k/8 + 1)*1000 + k%8), col_t'(k%8)})
                $display("FAIL fill_beat%0d got v=%b d=%0d c=%0d want d=%0d c=%0d", k, bus.out_valid, bus.out_data, bus.out_col, (k/8 + 1)*1000 + k%8, k%8);
            else passed++;
            @(negedge clk);
        end
        total++; if (bus.out_valid !== 1'b0) $display("FAIL fill_end got %b want 0", bus.out_valid); else passed++;
        total++; if (overflow !== 1'b1) $display("FAIL fill_sticky got %b want 1", overflow); else passed++;
        total++; if (almost_full !== 1'b0) $display("FAIL fill_af_end got %b want 0", almost_full); else passed++;
        pulse_clear();
        total++; if (overflow !== 1'b0) $display("FAIL fill_clear got %b want 0", overflow); else passed++;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        push_row(-2000);
        push_row(3000);
        for (int k = 0; k < 2 * ARRAY_N; k++) begin
            total++;
            if ({bus.out_valid, bus.out_data, bus.out_col, bus.out_last} !== {1'b1, psum_t'((k < 8 ? -2000 : 3000) + k%8), col_t'(k%8), k%8 == 7})
                $display("FAIL b2b_beat%0d got v=%b d=%0d c=%0d l=%b want d=%0d c=%0d", k, bus.out_valid, bus.out_data, bus.out_col, bus.out_last, (k < 8 ? -2000 : 3000) + k%8, k%8);
            else passed++;
            @(negedge clk);
        end
        total++; if (bus.out_valid !== 1'b0) $display("FAIL b2b_end got %b want 0", bus.out_valid); else passed++;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_double_capture();
        bus.out_ready = 1'b0;
        idle_in();
        set_col(2, 111);
        @(negedge clk);
        total++; if (overflow !== 1'b0) $display("FAIL dbl_first got %b want 0", overflow); else passed++;
        idle_in();
        set_col(2, 222);
        @(negedge clk);
        total++; if (overflow !== 1'b1) $display("FAIL dbl_second got %b want 1", overflow); else passed++;
        idle_in();
        for (int j = 0; j < ARRAY_N; j++) if (j != 2) set_col(j, 50 + j);
        @(negedge clk);
        idle_in();
        @(negedge clk);
        bus.out_ready = 1'b1;
        for (int b = 0; b < ARRAY_N; b++) begin
            total++;
            if ({bus.out_valid, bus.out_data} !== {1'b1, psum_t'(b == 2 ? 222 : 50 + b)})
                $display("FAIL dbl_beat%0d got v=%b d=%0d want %0d", b, bus.out_valid, bus.out_data, b == 2 ? 222 : 50 + b);
            else passed++;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
        pulse_clear();
        total++; if (overflow !== 1'b0) $display("FAIL dbl_clear got %b want 0", overflow); else passed++;
    endtask

    task automatic test_reset_relu();
        psum_t neg_exp;
`ifdef PSUM_DRAIN_RELU_EN
        neg_exp = '0;
`else
        neg_exp = 24'hFFFFFB;
`endif
        bus.out_ready = 1'b0;
        idle_in();
        set_col(0, -5);
        for (int j = 1; j < ARRAY_N; j++) set_col(j, j);
        @(negedge clk);
        idle_in();
        push_row(700);
        total++; if (bus.out_valid !== 1'b1) $display("FAIL relu_valid got %b want 1", bus.out_valid); else passed++;
        total++; if (bus.out_data !== neg_exp) $display("FAIL relu_data got %h want %h", bus.out_data, neg_exp); else passed++;
        rst_n = 1'b0;
        #1;
        total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_async got %b want 0", bus.out_valid); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            total++; if (bus.out_valid !== 1'b0) $display("FAIL rst_flush got %b want 0", bus.out_valid); else passed++;
        end
        total++; if (almost_full !== 1'b0) $display("FAIL rst_afull got %b want 0", almost_full); else passed++;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        idle_in();
        bus.out_ready = 1'b0;
        test_reset();
        test_skewed();
        test_backpressure();
        test_fill();
        test_back_to_back();
        test_double_capture();
        test_reset_relu();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end
endmodule
